// File: rtl/player_controller_pkg.sv
// rtl/player_controller_pkg.sv - pose encodings and screen/sprite geometry shared by the player engine
package player_controller_pkg;

    typedef enum logic [2:0] {
        IDLE_STATE        = 3'd0,
        WALK_STATE        = 3'd1,
        JUMP_STATE        = 3'd2,
        CROUCH_STATE      = 3'd3,
        MELEE_STATE_RIGHT = 3'd4,
        MELEE_STATE_LEFT  = 3'd5,
        CAST_STATE        = 3'd6,
        STUN_STATE        = 3'd7
    } player_state_e;

    localparam logic [9:0] SPRITE_WIDTH  = 10'd32;
    localparam logic [9:0] SPRITE_HEIGHT = 10'd64;
    localparam logic [9:0] SCREEN_W      = 10'd640;
    localparam logic [9:0] FIREBALL_PARK = 10'h3FF;

endpackage

// File: rtl/player_controller_if.sv
// rtl/player_controller_if.sv - button/hit inputs and pose/fireball outputs of one player engine
interface player_controller_if;

    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_punch;
    logic       btn_fire;
    logic       player_reset;
    logic       self_hit;
    logic       opponent_hit;
    logic [1:0] game_over;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [2:0] player_state;
    logic       player_direction;
    logic [9:0] fireball_x;
    logic [9:0] fireball_y;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down, btn_punch, btn_fire,
               player_reset, self_hit, opponent_hit, game_over,
        input  player_x, player_y, player_state, player_direction, fireball_x, fireball_y
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down, btn_punch, btn_fire,
               player_reset, self_hit, opponent_hit, game_over,
        output player_x, player_y, player_state, player_direction, fireball_x, fireball_y
    );

endinterface

// File: rtl/fireball_mover.sv
// rtl/fireball_mover.sv - spawns, advances and parks the single projectile of one player
module fireball_mover
    import player_controller_pkg::*;
#(
    parameter int FIRE_SPEED = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       spawn,
    input  logic       park,
    input  logic       hit_park,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  logic       spawn_right,
    output logic [9:0] fireball_x,
    output logic [9:0] fireball_y,
    output logic       active
);

    localparam logic signed [10:0] STEP   = 11'(FIRE_SPEED);
    localparam logic signed [10:0] X_LAST = $signed({1'b0, SCREEN_W}) - 11'sd1;

    logic              right_q;
    logic signed [10:0] x_next;

    // Candidate position one frame along the launch direction; 11-bit so leaving the screen on either side is visible
    always_comb begin
        x_next = right_q ? $signed({1'b0, fireball_x}) + STEP
                         : $signed({1'b0, fireball_x}) - STEP;
    end

    // Park beats spawn beats advance; launch direction is frozen at spawn
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fireball_x <= FIREBALL_PARK;
            fireball_y <= FIREBALL_PARK;
            active     <= 1'b0;
            right_q    <= 1'b0;
        end else if (frame_tick) begin
            if (park) begin
                fireball_x <= FIREBALL_PARK;
                fireball_y <= FIREBALL_PARK;
                active     <= 1'b0;
            end else if (spawn) begin
                fireball_x <= spawn_x;
                fireball_y <= spawn_y;
                right_q    <= spawn_right;
                active     <= 1'b1;
            end else if (active) begin
                if (hit_park || (x_next < 11'sd0) || (x_next > X_LAST)) begin
                    fireball_x <= FIREBALL_PARK;
                    fireball_y <= FIREBALL_PARK;
                    active     <= 1'b0;
                end else begin
                    fireball_x <= x_next[9:0];
                end
            end
        end
    end

endmodule

// File: rtl/player_controller.sv
// rtl/player_controller.sv - per-player motion/attack engine, one step per frame_tick
module player_controller
    import player_controller_pkg::*;
#(
    parameter logic [9:0] START_X      = 10'd160,
    parameter logic       START_RIGHT  = 1'b1,
    parameter logic [9:0] FLOOR_Y      = 10'd400,
    parameter logic [9:0] X_MIN        = 10'd16,
    parameter logic [9:0] X_MAX        = 10'd624,
    parameter int         WALK_SPEED   = 2,
    parameter int         JUMP_V0      = 12,
    parameter int         MELEE_FRAMES = 12,
    parameter int         CAST_FRAMES  = 8,
    parameter int         STUN_FRAMES  = 20,
    parameter int         FIRE_SPEED   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    player_controller_if.slave bus
);

    localparam logic [4:0]         MELEE_LAST = 5'(MELEE_FRAMES - 1);
    localparam logic [4:0]         CAST_LAST  = 5'(CAST_FRAMES - 1);
    localparam logic [4:0]         STUN_LAST  = 5'(STUN_FRAMES - 1);
    localparam logic signed [5:0]  JUMP_VEL   = 6'(JUMP_V0);
    localparam logic signed [11:0] WALK_STEP  = 12'(WALK_SPEED);

    player_state_e      state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               dir_q, dir_d, air_q, air_d;
    logic signed [5:0]  vel_q, vel_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               fire_prev_q, fire_prev_d, punch_prev_q, punch_prev_d;
    logic               self_hit_q, hit_flag_q, opp_hit_q, opp_flag_q;
    logic               fire_edge, punch_edge, lr_one, landed;
    logic signed [11:0] x_calc;
    logic [9:0]         x_walk;
    logic signed [10:0] y_calc;
    logic               spawn, park_all, fb_active;
    logic [9:0]         spawn_x, spawn_y;

    assign fire_edge  = bus.btn_fire & ~fire_prev_q;
    assign punch_edge = bus.btn_punch & ~punch_prev_q;
    assign lr_one     = bus.btn_left ^ bus.btn_right;
    assign spawn_x    = dir_q ? x_q + (SPRITE_WIDTH >> 1) : x_q - (SPRITE_WIDTH >> 1);
    assign spawn_y    = y_q - (SPRITE_HEIGHT >> 1);

    // Horizontal step with clamping, and the ballistic vertical step, both in widened signed arithmetic
    always_comb begin
        x_calc = bus.btn_left ? $signed({2'b00, x_q}) - WALK_STEP
                              : $signed({2'b00, x_q}) + WALK_STEP;
        if (x_calc < $signed({2'b00, X_MIN})) begin
            x_walk = X_MIN;
        end else if (x_calc > $signed({2'b00, X_MAX})) begin
            x_walk = X_MAX;
        end else begin
            x_walk = x_calc[9:0];
        end
        y_calc = $signed({1'b0, y_q}) - $signed({{5{vel_q[5]}}, vel_q});
    end

    // Per-frame next-state: player_reset > game_over > airborne physics, then hit > pose rules
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        vel_d        = vel_q;
        air_d        = air_q;
        cnt_d        = cnt_q;
        fire_prev_d  = fire_prev_q;
        punch_prev_d = punch_prev_q;
        spawn        = 1'b0;
        park_all     = 1'b0;
        landed       = 1'b0;
        if (bus.frame_tick) begin
            if (bus.player_reset) begin
                state_d      = IDLE_STATE;
                x_d          = START_X;
                y_d          = FLOOR_Y;
                dir_d        = START_RIGHT;
                vel_d        = '0;
                air_d        = 1'b0;
                cnt_d        = '0;
                fire_prev_d  = 1'b0;
                punch_prev_d = 1'b0;
                park_all     = 1'b1;
            end else if (bus.game_over != 2'd0) begin
                fire_prev_d  = bus.btn_fire;
                punch_prev_d = bus.btn_punch;
                state_d      = IDLE_STATE;
                y_d          = FLOOR_Y;
                vel_d        = '0;
                air_d        = 1'b0;
                cnt_d        = '0;
                park_all     = 1'b1;
            end else begin
                fire_prev_d  = bus.btn_fire;
                punch_prev_d = bus.btn_punch;
                // Vertical motion keeps running while airborne, even when stunned
                if (air_q) begin
                    if (y_calc >= $signed({1'b0, FLOOR_Y})) begin
                        y_d    = FLOOR_Y;
                        vel_d  = '0;
                        air_d  = 1'b0;
                        landed = 1'b1;
                    end else begin
                        y_d   = y_calc[9:0];
                        vel_d = vel_q - 6'sd1;
                    end
                end
                if (hit_flag_q) begin
                    state_d = STUN_STATE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        IDLE_STATE, WALK_STATE, CROUCH_STATE: begin
                            cnt_d = '0;
                            if (fire_edge && !fb_active) begin
                                state_d = CAST_STATE;
                                spawn   = 1'b1;
                            end else if (punch_edge) begin
                                state_d = dir_q ? MELEE_STATE_RIGHT : MELEE_STATE_LEFT;
                            end else if (bus.btn_up) begin
                                // The launch frame already rises by the full initial velocity
                                state_d = JUMP_STATE;
                                y_d     = y_q - 10'(JUMP_V0);
                                vel_d   = JUMP_VEL - 6'sd1;
                                air_d   = 1'b1;
                            end else if (bus.btn_down) begin
                                state_d = CROUCH_STATE;
                            end else if (lr_one) begin
                                state_d = WALK_STATE;
                                x_d     = x_walk;
                                dir_d   = bus.btn_right;
                            end else begin
                                state_d = IDLE_STATE;
                            end
                        end
                        JUMP_STATE: begin
                            if (lr_one) begin
                                x_d   = x_walk;
                                dir_d = bus.btn_right;
                            end
                            if (landed) begin
                                state_d = IDLE_STATE;
                            end
                        end
                        MELEE_STATE_RIGHT, MELEE_STATE_LEFT: begin
                            if (cnt_q == MELEE_LAST) begin
                                state_d = IDLE_STATE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        CAST_STATE: begin
                            if (cnt_q == CAST_LAST) begin
                                state_d = IDLE_STATE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        STUN_STATE: begin
                            // A stun that wears off mid-air hands back to the jump arc
                            if (cnt_q == STUN_LAST) begin
                                state_d = air_d ? JUMP_STATE : IDLE_STATE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        default: begin
                            state_d = IDLE_STATE;
                        end
                    endcase
                end
            end
        end
    end

    // Pose/motion registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE_STATE;
            x_q          <= START_X;
            y_q          <= FLOOR_Y;
            dir_q        <= START_RIGHT;
            vel_q        <= '0;
            air_q        <= 1'b0;
            cnt_q        <= '0;
            fire_prev_q  <= 1'b0;
            punch_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
            vel_q        <= vel_d;
            air_q        <= air_d;
            cnt_q        <= cnt_d;
            fire_prev_q  <= fire_prev_d;
            punch_prev_q <= punch_prev_d;
        end
    end

    // Hit edges are caught every clock so a pulse between frames is not lost; each frame consumes them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            self_hit_q <= 1'b0;
            hit_flag_q <= 1'b0;
            opp_hit_q  <= 1'b0;
            opp_flag_q <= 1'b0;
        end else begin
            self_hit_q <= bus.self_hit;
            opp_hit_q  <= bus.opponent_hit;
            if (bus.self_hit && !self_hit_q) begin
                hit_flag_q <= 1'b1;
            end else if (bus.frame_tick) begin
                hit_flag_q <= 1'b0;
            end
            if (bus.opponent_hit && !opp_hit_q) begin
                opp_flag_q <= 1'b1;
            end else if (bus.frame_tick) begin
                opp_flag_q <= 1'b0;
            end
        end
    end

    fireball_mover #(
        .FIRE_SPEED (FIRE_SPEED)
    ) u_fireball_mover (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (bus.frame_tick),
        .spawn       (spawn),
        .park        (park_all),
        .hit_park    (opp_flag_q),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_right (dir_q),
        .fireball_x  (bus.fireball_x),
        .fireball_y  (bus.fireball_y),
        .active      (fb_active)
    );

    assign bus.player_x         = x_q;
    assign bus.player_y         = y_q;
    assign bus.player_state     = state_q;
    assign bus.player_direction = dir_q;

endmodule

// File: tb/tb_player_controller.sv
// tb/tb_player_controller.sv - directed and randomized frame-level checks of player_controller
module tb_player_controller;

    localparam int FLOOR = 400;
    localparam int V0    = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    player_controller_if bus();

    player_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: positions as plain integers, jump as frames-since-launch
    int m_x, m_y, m_state, m_cnt, m_t, m_fx, m_fy;
    bit m_dir, m_air, m_fact, m_fdir, m_fprev, m_pprev;

    function automatic int clampw(input int v);
        if (v < 16) return 16;
        if (v > 624) return 624;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 160; m_y = FLOOR; m_state = 0; m_cnt = 0; m_t = 0;
        m_fx = 1023; m_fy = 1023;
        m_dir = 1; m_air = 0; m_fact = 0; m_fdir = 0; m_fprev = 0; m_pprev = 0;
    endtask

    task automatic model_tick(input bit l, r, u, d, p, f, hit, ohit, pr, input logic [1:0] go);
        bit fedge, pedge, fb_was, one, landed;
        int nx, ny, hold;
        fedge = f && !m_fprev;
        pedge = p && !m_pprev;
        fb_was = m_fact;
        one = (l != r);
        landed = 0;
        if (pr) begin
            model_reset();
            return;
        end
        m_fprev = f;
        m_pprev = p;
        if (go != 2'd0) begin
            m_state = 0; m_y = FLOOR; m_air = 0; m_t = 0; m_cnt = 0;
            m_fact = 0; m_fx = 1023; m_fy = 1023;
            return;
        end
        if (m_fact) begin
            nx = m_fdir ? m_fx + 4 : m_fx - 4;
            if (ohit || nx < 0 || nx > 639) begin
                m_fact = 0; m_fx = 1023; m_fy = 1023;
            end else begin
                m_fx = nx;
            end
        end
        if (m_air) begin
            m_t++;
            ny = FLOOR - (V0 * m_t - m_t * (m_t - 1) / 2);
            if (ny >= FLOOR) begin
                m_y = FLOOR; m_air = 0; m_t = 0; landed = 1;
            end else begin
                m_y = ny;
            end
        end
        if (hit) begin
            m_state = 7;
            m_cnt = 0;
        end else begin
            case (m_state)
                0, 1, 3: begin
                    m_cnt = 0;
                    if (fedge && !fb_was) begin
                        m_state = 6; m_fact = 1; m_fdir = m_dir;
                        m_fx = m_dir ? m_x + 16 : m_x - 16;
                        m_fy = m_y - 32;
                    end else if (pedge) begin
                        m_state = m_dir ? 4 : 5;
                    end else if (u) begin
                        m_state = 2; m_air = 1; m_t = 1; m_y = FLOOR - V0;
                    end else if (d) begin
                        m_state = 3;
                    end else if (one) begin
                        m_state = 1; m_dir = r; m_x = clampw(m_x + (r ? 2 : -2));
                    end else begin
                        m_state = 0;
                    end
                end
                2: begin
                    if (one) begin
                        m_dir = r; m_x = clampw(m_x + (r ? 2 : -2));
                    end
                    if (landed) m_state = 0;
                end
                default: begin
                    hold = (m_state == 6) ? 8 : (m_state == 7) ? 20 : 12;
                    m_cnt++;
                    if (m_cnt == hold) begin
                        m_cnt = 0;
                        m_state = (m_state == 7 && m_air) ? 2 : 0;
                    end
                end
            endcase
        end
    endtask

    // One video frame: set levels, optional mid-frame hit pulses, then the frame_tick pulse
    task automatic step(input bit l, r, u, d, p, f, hit, ohit, pr, input logic [1:0] go);
        @(negedge clk);
        bus.btn_left = l; bus.btn_right = r; bus.btn_up = u; bus.btn_down = d;
        bus.btn_punch = p; bus.btn_fire = f; bus.player_reset = pr; bus.game_over = go;
        @(negedge clk);
        bus.self_hit = hit; bus.opponent_hit = ohit;
        @(negedge clk);
        bus.self_hit = 1'b0; bus.opponent_hit = 1'b0;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick(l, r, u, d, p, f, hit, ohit, pr, go);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic test_reset();
        bus.frame_tick = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_up = 0; bus.btn_down = 0;
        bus.btn_punch = 0; bus.btn_fire = 0; bus.player_reset = 0; bus.self_hit = 0;
        bus.opponent_hit = 0; bus.game_over = 2'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++; if (bus.player_x !== 10'd160) begin errors++; $display("FAIL reset_x got %0d exp 160", bus.player_x); end
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.player_state); end
        checks++; if (bus.fireball_x !== 10'h3FF) begin errors++; $display("FAIL reset_fx got %0h exp 3ff", bus.fireball_x); end
        reset_n = 1'b1;
        idle(10);
        checks++; if (bus.player_x !== 10'd160) begin errors++; $display("FAIL idle_x got %0d exp 160", bus.player_x); end
        checks++; if (bus.player_y !== 10'd400) begin errors++; $display("FAIL idle_y got %0d exp 400", bus.player_y); end
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL idle_state got %0d exp 0", bus.player_state); end
        checks++; if (bus.player_direction !== 1'b1) begin errors++; $display("FAIL idle_dir got %0d exp 1", bus.player_direction); end
        checks++; if (bus.fireball_x !== 10'h3FF) begin errors++; $display("FAIL idle_fx got %0h exp 3ff", bus.fireball_x); end
        checks++; if (bus.fireball_y !== 10'h3FF) begin errors++; $display("FAIL idle_fy got %0h exp 3ff", bus.fireball_y); end
    endtask

    task automatic test_walk();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_x !== 10'd150) begin errors++; $display("FAIL walk_x got %0d exp 150", bus.player_x); end
        checks++; if (bus.player_direction !== 1'b0) begin errors++; $display("FAIL walk_dir got %0d exp 0", bus.player_direction); end
        checks++; if (bus.player_state !== 3'd1) begin errors++; $display("FAIL walk_state got %0d exp 1", bus.player_state); end
        for (int i = 0; i < 70; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_x !== 10'd16) begin errors++; $display("FAIL walk_clamp got %0d exp 16", bus.player_x); end
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL walk_both got %0d exp 0", bus.player_state); end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_x !== 10'd18) begin errors++; $display("FAIL walk_right got %0d exp 18", bus.player_x); end
    endtask

    task automatic test_jump();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd2) begin errors++; $display("FAIL jump_state got %0d exp 2", bus.player_state); end
        checks++; if (bus.player_y !== 10'd388) begin errors++; $display("FAIL jump_y1 got %0d exp 388", bus.player_y); end
        for (int t = 2; t <= 25; t++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            if (t == 13) begin
                checks++; if (bus.player_y !== 10'd322) begin errors++; $display("FAIL jump_apex got %0d exp 322", bus.player_y); end
            end
            if (t == 24) begin
                checks++; if (bus.player_state !== 3'd2) begin errors++; $display("FAIL jump_air24 got %0d exp 2", bus.player_state); end
            end
        end
        checks++; if (bus.player_y !== 10'd400) begin errors++; $display("FAIL jump_land_y got %0d exp 400", bus.player_y); end
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL jump_land_state got %0d exp 0", bus.player_state); end
    endtask

    task automatic test_fireball();
        int exp_fx;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd6) begin errors++; $display("FAIL cast_state got %0d exp 6", bus.player_state); end
        checks++; if (bus.fireball_x !== 10'd176) begin errors++; $display("FAIL cast_fx got %0d exp 176", bus.fireball_x); end
        checks++; if (bus.fireball_y !== 10'd368) begin errors++; $display("FAIL cast_fy got %0d exp 368", bus.fireball_y); end
        for (int n = 1; n <= 120; n++) begin
            step(0, 0, 0, 0, 0, n == 20, 0, 0, 0, 2'd0);
            exp_fx = (176 + 4 * n <= 639) ? 176 + 4 * n : 1023;
            checks++; if (bus.fireball_x !== 10'(exp_fx)) begin errors++; $display("FAIL fb_x n=%0d got %0d exp %0d", n, bus.fireball_x, exp_fx); end
            if (n == 20) begin
                checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL fire_in_flight got %0d exp 0", bus.player_state); end
            end
        end
    endtask

    task automatic test_melee_stun();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd4) begin errors++; $display("FAIL melee_state got %0d exp 4", bus.player_state); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd7) begin errors++; $display("FAIL stun_entry got %0d exp 7", bus.player_state); end
        for (int i = 1; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            checks++; if (bus.player_state !== 3'd7) begin errors++; $display("FAIL stun_hold i=%0d got %0d exp 7", i, bus.player_state); end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL stun_exit got %0d exp 0", bus.player_state); end
    endtask

    task automatic test_game_over();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0);
        checks++; if (bus.fireball_x !== 10'd138) begin errors++; $display("FAIL go_spawn got %0d exp 138", bus.fireball_x); end
        idle(8);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0);
        idle(2);
        checks++; if (bus.player_y !== 10'd367) begin errors++; $display("FAIL go_air_y got %0d exp 367", bus.player_y); end
        checks++; if (bus.fireball_x !== 10'd94) begin errors++; $display("FAIL go_fb_flight got %0d exp 94", bus.fireball_x); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
        checks++; if (bus.player_state !== 3'd0) begin errors++; $display("FAIL go_state got %0d exp 0", bus.player_state); end
        checks++; if (bus.player_y !== 10'd400) begin errors++; $display("FAIL go_y got %0d exp 400", bus.player_y); end
        checks++; if (bus.fireball_x !== 10'h3FF) begin errors++; $display("FAIL go_fx got %0h exp 3ff", bus.fireball_x); end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
        checks++; if (bus.player_x !== 10'd154) begin errors++; $display("FAIL go_frozen_x got %0d exp 154", bus.player_x); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2);
        checks++; if (bus.player_x !== 10'd160) begin errors++; $display("FAIL go_reset_x got %0d exp 160", bus.player_x); end
        checks++; if (bus.player_direction !== 1'b1) begin errors++; $display("FAIL go_reset_dir got %0d exp 1", bus.player_direction); end
    endtask

    task automatic test_random();
        bit l, r, u, d, p, f, hit, oh, pr;
        logic [1:0] go;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 400; i++) begin
            l = ($urandom_range(2) == 0); r = ($urandom_range(2) == 0);
            u = ($urandom_range(9) == 0); d = ($urandom_range(7) == 0);
            p = ($urandom_range(5) == 0); f = ($urandom_range(5) == 0);
            hit = ($urandom_range(14) == 0); oh = ($urandom_range(9) == 0);
            pr = ($urandom_range(99) == 0);
            go = ($urandom_range(49) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
            step(l, r, u, d, p, f, hit, oh, pr, go);
            checks++; if (bus.player_x !== 10'(m_x)) begin errors++; $display("FAIL rnd_x f=%0d got %0d exp %0d", i, bus.player_x, m_x); end
            checks++; if (bus.player_y !== 10'(m_y)) begin errors++; $display("FAIL rnd_y f=%0d got %0d exp %0d", i, bus.player_y, m_y); end
            checks++; if (bus.player_state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state f=%0d got %0d exp %0d", i, bus.player_state, m_state); end
            checks++; if (bus.player_direction !== m_dir) begin errors++; $display("FAIL rnd_dir f=%0d got %0d exp %0d", i, bus.player_direction, m_dir); end
            checks++; if (bus.fireball_x !== 10'(m_fx)) begin errors++; $display("FAIL rnd_fx f=%0d got %0d exp %0d", i, bus.fireball_x, m_fx); end
            checks++; if (bus.fireball_y !== 10'(m_fy)) begin errors++; $display("FAIL rnd_fy f=%0d got %0d exp %0d", i, bus.fireball_y, m_fy); end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_fireball();
        test_melee_stun();
        test_game_over();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
